instr_decoder: RTL and testbench
================================

// Module: instr_decoder
// PURPOSE
//  Instruction decoder/sequencer of the 8-bit CPU. It sits between the fetch stage (instr_byte plus two operand
//  bytes) and the datapath. Each clock it decodes the presented instruction and drives register-file write-back,
//  ALU control, SRAM access, LCD print handshake, jump and halt. It reports instr_size so the PC advances.
// PARAMETERS
//  none (8-bit data, 4 registers A..D = 00..11, 9-bit jump address are fixed)
// PORTS
//  clk         in   1  system clock; all state on rising edge
//  sys_rst     in   1  synchronous, active-high reset
//  instr_byte  in   8  opcode byte; [7:4] class, [3:0] fields
//  operand1    in   8  second instruction byte (imm / address)
//  operand2    in   8  third byte; only bit0 used (jump addr MSB)
//  lcd_done    in   1  LCD finished the current character
//  reg_a..reg_d in  8  current register file contents
//  reg_flags   in   8  flags; [0]=Z, [1]=C
//  res         in   8  ALU result
//  sram_data   in   8  SRAM read data
//  hlt         out  1  halt request
//  jmp_en      out  1  load PC with jmp_addr (1-cycle pulse)
//  jmp_addr    out  9  {operand2[0], operand1}
//  instr_size  out  2  PC increment: 1, 2, or 0 = stall
//  sram_addr   out  8  SRAM address
//  rd_en/wr_en out  1  SRAM read / write strobes
//  lcd_data    out  8  character to print
//  data_loc    out  8  SRAM write data (store source register)
//  loc_req     out  1  data_loc valid (asserted with wr_en)
//  strt        out  1  LCD start, held until lcd_done
//  reg_data    out  8  write-back data
//  reg_addr    out  2  write-back register (regfile writes every cycle)
//  alu_inst    out  3  ALU opcode
//  op_1/op_2   out  8  ALU operands
// BEHAVIOUR
//  - All outputs are registered; update 1 clock after instr_byte/operands change. Reset drives every output to 0.
//  - Idle write-back: instructions that write no register drive reg_addr=00, reg_data=reg_a (harmless rewrite).
//  - Register select r: 00=A, 01=B, 10=C, 11=D. Decode on instr_byte[7:4]:
//    0000 ddss MOV rd,rs: reg_addr=dd, reg_data=r[ss], size 1.
//    0001 ddxx MOV rd,imm: reg_addr=dd, reg_data=operand1, size 2.
//    0010 ddxx LOAD rd,[op1]: cycle1 sram_addr=operand1, rd_en=1, size 0; cycle2 reg_addr=dd, reg_data=sram_data,
//              rd_en=0, size 2.
//    0011 ssxx STORE [op1],rs: sram_addr=operand1, wr_en=1, loc_req=1, data_loc=r[ss], size 2; strobes 1 cycle.
//    0100 xxss PRNT rs: lcd_data=r[ss], strt=1, size 0 (stall) until lcd_done sampled 1. In that cycle strt=0
//              and size=1. strt is never re-asserted for the same instruction.
//    0101 ooox ALU: alu_inst=ooo, op_1=reg_a, op_2=reg_b, size 0. Next cycle reg_addr=00, reg_data=res, size 1.
//    0110 cccm JMP: jmp_addr={operand2[0],operand1}, size 2. Condition ccc: 000 always, 001 Z, 010 !Z, 011 C,
//              100 !C, others never. jmp_en=1 for one cycle if taken.
//    0111 xxxx HLT: hlt=1 while decoded, size 0. Not sticky: a new instr_byte is decoded normally.
//    1xxx xxxx NOP: size 1, all strobes 0.
//  - Strobes (rd_en, wr_en, loc_req, jmp_en) default 0 each cycle unless set above.
//  - Internal FSM: EXEC -> {LOAD2, ALU2, LCD_WAIT} -> EXEC.
//    - An instruction held constant re-executes each time the FSM returns to EXEC.
//    - lcd_done while not in LCD_WAIT is ignored.
//  - sys_rst mid-operation (e.g. LCD_WAIT) returns to EXEC with all outputs 0 next cycle.
// TESTING
//  - Reset, A..D=11/22/33/44, instr 0x10, op1=0x42, wait 5 clk -> reg_data=42, reg_addr=00, instr_size=2.
//  - instr 0x06 (MOV B,C), 2 clk -> reg_data=33, reg_addr=01, instr_size=1.
//  - instr 0x70, 2 clk -> hlt=1, instr_size=0; then instr 0x40 -> hlt=0 within 2 clk.
//  - instr 0x40, lcd_done=0, 2 clk -> lcd_data=11, strt=1, size 0. Pulse lcd_done -> strt=0, size=1.
//  - instr 0x62, op1=0x80, op2=1, flags Z=1 -> jmp_en 1-cycle pulse, jmp_addr=0x180; Z=0 -> jmp_en=0.
//  - instr 0x24, op1=0x10 -> rd_en=1, sram_addr=10; next clk reg_addr=01, reg_data=sram_data (0x55).

Source files
------------

// File: rtl/instr_decoder.sv
//------------------------------------------------------------------------------
// Module   : instr_decoder
// Brief    : 8-bit CPU instruction decoder/sequencer with registered outputs.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module instr_decoder (
    input  logic       clk,
    input  logic       sys_rst,
    input  logic [7:0] instr_byte,
    input  logic [7:0] operand1,
    input  logic [7:0] operand2,
    input  logic       lcd_done,
    input  logic [7:0] reg_a,
    input  logic [7:0] reg_b,
    input  logic [7:0] reg_c,
    input  logic [7:0] reg_d,
    input  logic [7:0] reg_flags,
    input  logic [7:0] res,
    input  logic [7:0] sram_data,
    output logic       hlt,
    output logic       jmp_en,
    output logic [8:0] jmp_addr,
    output logic [1:0] instr_size,
    output logic [7:0] sram_addr,
    output logic       rd_en,
    output logic       wr_en,
    output logic [7:0] lcd_data,
    output logic [7:0] data_loc,
    output logic       loc_req,
    output logic       strt,
    output logic [7:0] reg_data,
    output logic [1:0] reg_addr,
    output logic [2:0] alu_inst,
    output logic [7:0] op_1,
    output logic [7:0] op_2
);

    typedef enum logic [1:0] {
        EXEC     = 2'd0,
        LOAD2    = 2'd1,
        ALU2     = 2'd2,
        LCD_WAIT = 2'd3
    } state_t;

    state_t     state, state_nx;

    logic       hlt_nx, jmp_en_nx, rd_en_nx, wr_en_nx, loc_req_nx, strt_nx;
    logic [8:0] jmp_addr_nx;
    logic [1:0] size_nx, reg_addr_nx;
    logic [7:0] sram_addr_nx, lcd_data_nx, data_loc_nx, reg_data_nx;
    logic [7:0] op_1_nx, op_2_nx;
    logic [2:0] alu_inst_nx;

    logic [7:0] src_lo;   // register selected by instr_byte[1:0]
    logic [7:0] src_hi;   // register selected by instr_byte[3:2]
    logic       jmp_take;

    logic       flag_z, flag_c;
    assign flag_z = reg_flags[0];
    assign flag_c = reg_flags[1];

    logic unused_ok;
    assign unused_ok = &{1'b0, operand2[7:1], reg_flags[7:2]};

    always_comb begin
        src_lo = reg_a;
        case (instr_byte[1:0])
            2'b00:   src_lo = reg_a;
            2'b01:   src_lo = reg_b;
            2'b10:   src_lo = reg_c;
            default: src_lo = reg_d;
        endcase
        src_hi = reg_a;
        case (instr_byte[3:2])
            2'b00:   src_hi = reg_a;
            2'b01:   src_hi = reg_b;
            2'b10:   src_hi = reg_c;
            default: src_hi = reg_d;
        endcase
        jmp_take = 1'b0;
        case (instr_byte[3:1])
            3'b000:  jmp_take = 1'b1;
            3'b001:  jmp_take = flag_z;
            3'b010:  jmp_take = !flag_z;
            3'b011:  jmp_take = flag_c;
            3'b100:  jmp_take = !flag_c;
            default: jmp_take = 1'b0;
        endcase
    end

    always_comb begin
        state_nx     = state;
        hlt_nx       = 1'b0;
        jmp_en_nx    = 1'b0;
        jmp_addr_nx  = {operand2[0], operand1};
        size_nx      = 2'd1;
        sram_addr_nx = 8'h00;
        rd_en_nx     = 1'b0;
        wr_en_nx     = 1'b0;
        lcd_data_nx  = 8'h00;
        data_loc_nx  = 8'h00;
        loc_req_nx   = 1'b0;
        strt_nx      = 1'b0;
        reg_data_nx  = reg_a;   // idle write-back rewrites A with itself
        reg_addr_nx  = 2'b00;
        alu_inst_nx  = 3'b000;
        op_1_nx      = 8'h00;
        op_2_nx      = 8'h00;

        case (state)
            EXEC: begin
                if (instr_byte[7]) begin
                    size_nx = 2'd1;
                end else begin
                    case (instr_byte[6:4])
                        3'b000: begin
                            reg_addr_nx = instr_byte[3:2];
                            reg_data_nx = src_lo;
                            size_nx     = 2'd1;
                        end
                        3'b001: begin
                            reg_addr_nx = instr_byte[3:2];
                            reg_data_nx = operand1;
                            size_nx     = 2'd2;
                        end
                        3'b010: begin
                            sram_addr_nx = operand1;
                            rd_en_nx     = 1'b1;
                            size_nx      = 2'd0;
                            state_nx     = LOAD2;
                        end
                        3'b011: begin
                            sram_addr_nx = operand1;
                            wr_en_nx     = 1'b1;
                            loc_req_nx   = 1'b1;
                            data_loc_nx  = src_hi;
                            size_nx      = 2'd2;
                        end
                        3'b100: begin
                            lcd_data_nx = src_lo;
                            strt_nx     = 1'b1;
                            size_nx     = 2'd0;
                            state_nx    = LCD_WAIT;
                        end
                        3'b101: begin
                            alu_inst_nx = instr_byte[3:1];
                            op_1_nx     = reg_a;
                            op_2_nx     = reg_b;
                            size_nx     = 2'd0;
                            state_nx    = ALU2;
                        end
                        3'b110: begin
                            jmp_en_nx = jmp_take;
                            size_nx   = 2'd2;
                        end
                        default: begin
                            hlt_nx  = 1'b1;
                            size_nx = 2'd0;
                        end
                    endcase
                end
            end
            LOAD2: begin
                sram_addr_nx = operand1;
                reg_addr_nx  = instr_byte[3:2];
                reg_data_nx  = sram_data;
                size_nx      = 2'd2;
                state_nx     = EXEC;
            end
            ALU2: begin
                // Operands stay presented so res remains valid while written back.
                alu_inst_nx = instr_byte[3:1];
                op_1_nx     = reg_a;
                op_2_nx     = reg_b;
                reg_data_nx = res;
                size_nx     = 2'd1;
                state_nx    = EXEC;
            end
            default: begin
                lcd_data_nx = lcd_data;
                if (lcd_done) begin
                    size_nx  = 2'd1;
                    state_nx = EXEC;
                end else begin
                    strt_nx = 1'b1;
                    size_nx = 2'd0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state      <= EXEC;
            hlt        <= 1'b0;
            jmp_en     <= 1'b0;
            jmp_addr   <= 9'h000;
            instr_size <= 2'd0;
            sram_addr  <= 8'h00;
            rd_en      <= 1'b0;
            wr_en      <= 1'b0;
            lcd_data   <= 8'h00;
            data_loc   <= 8'h00;
            loc_req    <= 1'b0;
            strt       <= 1'b0;
            reg_data   <= 8'h00;
            reg_addr   <= 2'b00;
            alu_inst   <= 3'b000;
            op_1       <= 8'h00;
            op_2       <= 8'h00;
        end else begin
            state      <= state_nx;
            hlt        <= hlt_nx;
            jmp_en     <= jmp_en_nx;
            jmp_addr   <= jmp_addr_nx;
            instr_size <= size_nx;
            sram_addr  <= sram_addr_nx;
            rd_en      <= rd_en_nx;
            wr_en      <= wr_en_nx;
            lcd_data   <= lcd_data_nx;
            data_loc   <= data_loc_nx;
            loc_req    <= loc_req_nx;
            strt       <= strt_nx;
            reg_data   <= reg_data_nx;
            reg_addr   <= reg_addr_nx;
            alu_inst   <= alu_inst_nx;
            op_1       <= op_1_nx;
            op_2       <= op_2_nx;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_instr_decoder.sv
//------------------------------------------------------------------------------
// Module   : tb_instr_decoder
// Brief    : Directed self-checking bench for instr_decoder.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_instr_decoder;

    logic       clk = 1'b0;
    logic       sys_rst;
    logic [7:0] instr_byte, operand1, operand2;
    logic       lcd_done;
    logic [7:0] reg_a, reg_b, reg_c, reg_d, reg_flags, res, sram_data;
    logic       hlt, jmp_en, rd_en, wr_en, loc_req, strt;
    logic [8:0] jmp_addr;
    logic [1:0] instr_size, reg_addr;
    logic [7:0] sram_addr, lcd_data, data_loc, reg_data, op_1, op_2;
    logic [2:0] alu_inst;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    instr_decoder dut (
        .clk(clk), .sys_rst(sys_rst), .instr_byte(instr_byte),
        .operand1(operand1), .operand2(operand2), .lcd_done(lcd_done),
        .reg_a(reg_a), .reg_b(reg_b), .reg_c(reg_c), .reg_d(reg_d),
        .reg_flags(reg_flags), .res(res), .sram_data(sram_data),
        .hlt(hlt), .jmp_en(jmp_en), .jmp_addr(jmp_addr), .instr_size(instr_size),
        .sram_addr(sram_addr), .rd_en(rd_en), .wr_en(wr_en), .lcd_data(lcd_data),
        .data_loc(data_loc), .loc_req(loc_req), .strt(strt), .reg_data(reg_data),
        .reg_addr(reg_addr), .alu_inst(alu_inst), .op_1(op_1), .op_2(op_2)
    );

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        instr_byte = 8'h10; operand1 = 8'h42; operand2 = 8'h00; lcd_done = 1'b0;
        reg_a = 8'h11; reg_b = 8'h22; reg_c = 8'h33; reg_d = 8'h44;
        reg_flags = 8'h00; res = 8'h99; sram_data = 8'h55;
        tick(2);
        total++;
        if ({hlt, jmp_en, jmp_addr, instr_size, sram_addr, rd_en, wr_en, lcd_data, data_loc,
             loc_req, strt, reg_data, reg_addr, alu_inst, op_1, op_2} !== 98'd0)
            $display("FAIL reset_outputs: some output nonzero (reg_data=%h size=%0d)", reg_data, instr_size);
        else passed++;
        sys_rst = 1'b0;
    endtask

    task automatic test_mov_imm();
        instr_byte = 8'h10; operand1 = 8'h42;
        tick(5);
        total++;
        if ({reg_data, reg_addr, instr_size} !== {8'h42, 2'b00, 2'd2})
            $display("FAIL mov_imm: got data=%h addr=%0d size=%0d want 42/0/2", reg_data, reg_addr, instr_size);
        else passed++;
    endtask

    task automatic test_mov_reg();
        instr_byte = 8'h06;
        tick(2);
        total++;
        if ({reg_data, reg_addr, instr_size} !== {8'h33, 2'b01, 2'd1})
            $display("FAIL mov_reg: got data=%h addr=%0d size=%0d want 33/1/1", reg_data, reg_addr, instr_size);
        else passed++;
    endtask

    task automatic test_halt();
        instr_byte = 8'h70;
        tick(2);
        total++;
        if ({hlt, instr_size} !== {1'b1, 2'd0})
            $display("FAIL halt_on: got hlt=%b size=%0d want 1/0", hlt, instr_size);
        else passed++;
        instr_byte = 8'h40;
        tick(1);
        total++;
        if ({hlt, strt} !== 2'b01)
            $display("FAIL halt_release: got hlt=%b strt=%b want 0/1", hlt, strt);
        else passed++;
    endtask

    task automatic test_print();
        tick(1);
        total++;
        if ({lcd_data, strt, instr_size} !== {8'h11, 1'b1, 2'd0})
            $display("FAIL print_wait: got lcd=%h strt=%b size=%0d want 11/1/0", lcd_data, strt, instr_size);
        else passed++;
        lcd_done = 1'b1;
        tick(1);
        total++;
        if ({strt, instr_size} !== {1'b0, 2'd1})
            $display("FAIL print_done: got strt=%b size=%0d want 0/1", strt, instr_size);
        else passed++;
        instr_byte = 8'h80;
        tick(1);
        total++;
        if ({strt, instr_size} !== {1'b0, 2'd1})
            $display("FAIL print_nop: got strt=%b size=%0d want 0/1", strt, instr_size);
        else passed++;
        // lcd_done high while in EXEC must not cut the print short
        instr_byte = 8'h43;
        tick(1);
        total++;
        if ({lcd_data, strt, instr_size} !== {8'h44, 1'b1, 2'd0})
            $display("FAIL print_ignore_done: got lcd=%h strt=%b size=%0d want 44/1/0", lcd_data, strt, instr_size);
        else passed++;
        tick(1);
        total++;
        if ({strt, instr_size} !== {1'b0, 2'd1})
            $display("FAIL print_done2: got strt=%b size=%0d want 0/1", strt, instr_size);
        else passed++;
        lcd_done = 1'b0;
        instr_byte = 8'h80;
        tick(1);
    endtask

    task automatic test_jump();
        logic [7:0] ins [6];
        logic [7:0] flg [6];
        logic       exp [6];
        ins = '{8'h62, 8'h62, 8'h60, 8'h66, 8'h68, 8'h6A};
        flg = '{8'h01, 8'h00, 8'h00, 8'h02, 8'h02, 8'h03};
        exp = '{1'b1,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0};
        operand1 = 8'h80; operand2 = 8'h01;
        for (int k = 0; k < 6; k++) begin
            instr_byte = ins[k]; reg_flags = flg[k];
            tick(1);
            total++;
            if ({jmp_en, jmp_addr, instr_size} !== {exp[k], 9'h180, 2'd2})
                $display("FAIL jump_%0d: got en=%b addr=%h size=%0d want %b/180/2",
                         k, jmp_en, jmp_addr, instr_size, exp[k]);
            else passed++;
            instr_byte = 8'h80;
            tick(1);
            total++;
            if (jmp_en !== 1'b0)
                $display("FAIL jump_pulse_%0d: got en=%b want 0", k, jmp_en);
            else passed++;
        end
        reg_flags = 8'h00; operand2 = 8'h00;
    endtask

    task automatic test_load();
        instr_byte = 8'h24; operand1 = 8'h10; sram_data = 8'h55;
        tick(1);
        total++;
        if ({rd_en, sram_addr, instr_size, reg_addr, reg_data} !== {1'b1, 8'h10, 2'd0, 2'b00, 8'h11})
            $display("FAIL load_c1: got rd=%b addr=%h size=%0d ra=%0d rd=%h want 1/10/0/0/11",
                     rd_en, sram_addr, instr_size, reg_addr, reg_data);
        else passed++;
        tick(1);
        total++;
        if ({rd_en, instr_size, reg_addr, reg_data} !== {1'b0, 2'd2, 2'b01, 8'h55})
            $display("FAIL load_c2: got rd=%b size=%0d ra=%0d rd=%h want 0/2/1/55",
                     rd_en, instr_size, reg_addr, reg_data);
        else passed++;
        instr_byte = 8'h80;
        tick(1);
    endtask

    task automatic test_store();
        instr_byte = 8'h3C; operand1 = 8'h20;
        tick(1);
        total++;
        if ({wr_en, loc_req, data_loc, sram_addr, instr_size, reg_addr} !== {2'b11, 8'h44, 8'h20, 2'd2, 2'b00})
            $display("FAIL store: got wr=%b lr=%b dl=%h addr=%h size=%0d want 1/1/44/20/2",
                     wr_en, loc_req, data_loc, sram_addr, instr_size);
        else passed++;
        instr_byte = 8'h80;
        tick(1);
        total++;
        if ({wr_en, loc_req} !== 2'b00)
            $display("FAIL store_pulse: got wr=%b lr=%b want 0/0", wr_en, loc_req);
        else passed++;
    endtask

    task automatic test_alu();
        instr_byte = 8'h5A; res = 8'h99;
        tick(1);
        total++;
        if ({alu_inst, op_1, op_2, instr_size} !== {3'd5, 8'h11, 8'h22, 2'd0})
            $display("FAIL alu_c1: got op=%0d a=%h b=%h size=%0d want 5/11/22/0", alu_inst, op_1, op_2, instr_size);
        else passed++;
        tick(1);
        total++;
        if ({reg_addr, reg_data, instr_size} !== {2'b00, 8'h99, 2'd1})
            $display("FAIL alu_c2: got ra=%0d rd=%h size=%0d want 0/99/1", reg_addr, reg_data, instr_size);
        else passed++;
        instr_byte = 8'h80;
        tick(1);
    endtask

    task automatic test_reset_mid();
        instr_byte = 8'h41;
        tick(1);
        sys_rst = 1'b1;
        tick(1);
        total++;
        if ({strt, lcd_data, instr_size, reg_data} !== 19'd0)
            $display("FAIL reset_mid: got strt=%b lcd=%h size=%0d rd=%h want all 0", strt, lcd_data, instr_size, reg_data);
        else passed++;
        sys_rst = 1'b0;
        instr_byte = 8'h80;
        tick(1);
        total++;
        if ({strt, instr_size} !== {1'b0, 2'd1})
            $display("FAIL reset_mid_exec: got strt=%b size=%0d want 0/1", strt, instr_size);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_mov_imm();
        test_mov_reg();
        test_halt();
        test_print();
        test_jump();
        test_load();
        test_store();
        test_alu();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
